// File: rtl/mem_port_arbiter.sv
// Shares one 32-bit memory port between instruction fetch and data access.
// Sequences a single outstanding req/gnt/rvalid transaction, drives byte lanes,
// and reports misaligned data accesses and bus timeouts to the requester.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        inst_rd_en,
  input  logic [31:0] inst_addr,
  output logic        inst_ready,
  output logic [31:0] inst_rdata,
  output logic        inst_err,
  input  logic        data_rd_en,
  input  logic        data_wr_en,
  input  logic [31:0] data_addr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_wdata,
  output logic        data_ready,
  output logic [31:0] data_rdata,
  output logic        data_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int TW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t          state, state_nxt;
  logic            owner_inst, owner_inst_nxt;
  logic [SW-1:0]   starve_cnt, starve_cnt_nxt;
  logic [TW-1:0]   tmo_cnt, tmo_cnt_nxt, tmo_inc;
  logic            timeout_hit, data_pend, grant_inst;
  logic            inst_ready_nxt, inst_err_nxt, data_ready_nxt, data_err_nxt;
  logic [31:0]     inst_rdata_nxt, data_rdata_nxt;
  logic            mem_req_nxt, mem_we_nxt;
  logic [31:0]     mem_addr_nxt, mem_wdata_nxt;
  logic [3:0]      mem_be_nxt;

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == 2'b11) || ((size == 2'b01) && off[0]) || ((size == 2'b10) && (off != 2'b00));
  endfunction

  assign data_pend   = data_rd_en | data_wr_en;
  assign grant_inst  = inst_rd_en && (!data_pend || (starve_cnt == SW'(STARVE_MAX)));
  assign tmo_inc     = tmo_cnt + TW'(1);
  assign timeout_hit = (TIMEOUT != 0) && (tmo_inc == TW'(TIMEOUT));

  // Next-state, arbitration, lane formatting and completion reporting
  always_comb begin
    state_nxt      = state;
    owner_inst_nxt = owner_inst;
    starve_cnt_nxt = starve_cnt;
    tmo_cnt_nxt    = tmo_cnt;
    inst_ready_nxt = 1'b0;
    inst_err_nxt   = 1'b0;
    data_ready_nxt = 1'b0;
    data_err_nxt   = 1'b0;
    inst_rdata_nxt = inst_rdata;
    data_rdata_nxt = data_rdata;
    mem_req_nxt    = mem_req;
    mem_addr_nxt   = mem_addr;
    mem_we_nxt     = mem_we;
    mem_be_nxt     = mem_be;
    mem_wdata_nxt  = mem_wdata;
    case (state)
      IDLE: begin
        if (inst_rd_en || data_pend) begin
          tmo_cnt_nxt = '0;
          if (grant_inst) begin
            owner_inst_nxt = 1'b1;
            starve_cnt_nxt = '0;
            mem_addr_nxt   = inst_addr & 32'hFFFF_FFFC;
            mem_we_nxt     = 1'b0;
            mem_be_nxt     = 4'b1111;
            mem_wdata_nxt  = '0;
            mem_req_nxt    = 1'b1;
            state_nxt      = REQ;
          end else begin
            owner_inst_nxt = 1'b0;
            if (inst_rd_en && (starve_cnt != SW'(STARVE_MAX)))
              starve_cnt_nxt = starve_cnt + SW'(1);
            if (misaligned(data_size, data_addr[1:0])) begin
              // Rejected without touching the bus
              data_ready_nxt = 1'b1;
              data_err_nxt   = 1'b1;
              data_rdata_nxt = '0;
              state_nxt      = DONE;
            end else begin
              mem_addr_nxt  = data_addr & 32'hFFFF_FFFC;
              mem_we_nxt    = data_wr_en;
              mem_be_nxt    = data_wr_en ? lane_be(data_size, data_addr[1:0]) : 4'b1111;
              mem_wdata_nxt = data_wr_en ? lane_wdata(data_size, data_wdata) : data_wdata;
              mem_req_nxt   = 1'b1;
              state_nxt     = REQ;
            end
          end
        end
      end
      REQ: begin
        tmo_cnt_nxt = tmo_inc;
        if (timeout_hit) begin
          mem_req_nxt = 1'b0;
          state_nxt   = DONE;
          if (owner_inst) begin
            inst_ready_nxt = 1'b1; inst_err_nxt = 1'b1; inst_rdata_nxt = '0;
          end else begin
            data_ready_nxt = 1'b1; data_err_nxt = 1'b1; data_rdata_nxt = '0;
          end
        end else if (mem_gnt) begin
          mem_req_nxt = 1'b0;
          state_nxt   = RESP;
        end
      end
      RESP: begin
        tmo_cnt_nxt = tmo_inc;
        if (mem_rvalid) begin
          state_nxt = DONE;
          if (owner_inst) begin
            inst_ready_nxt = 1'b1; inst_rdata_nxt = mem_rdata;
          end else begin
            data_ready_nxt = 1'b1; data_rdata_nxt = mem_rdata;
          end
        end else if (timeout_hit) begin
          state_nxt = DONE;
          if (owner_inst) begin
            inst_ready_nxt = 1'b1; inst_err_nxt = 1'b1; inst_rdata_nxt = '0;
          end else begin
            data_ready_nxt = 1'b1; data_err_nxt = 1'b1; data_rdata_nxt = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; reset wins, otherwise advance only on clk_en
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner_inst <= 1'b0;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      inst_ready <= 1'b0;
      inst_err   <= 1'b0;
      inst_rdata <= '0;
      data_ready <= 1'b0;
      data_err   <= 1'b0;
      data_rdata <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_wdata  <= '0;
    end else if (clk_en) begin
      state      <= state_nxt;
      owner_inst <= owner_inst_nxt;
      starve_cnt <= starve_cnt_nxt;
      tmo_cnt    <= tmo_cnt_nxt;
      inst_ready <= inst_ready_nxt;
      inst_err   <= inst_err_nxt;
      inst_rdata <= inst_rdata_nxt;
      data_ready <= data_ready_nxt;
      data_err   <= data_err_nxt;
      data_rdata <= data_rdata_nxt;
      mem_req    <= mem_req_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_we     <= mem_we_nxt;
      mem_be     <= mem_be_nxt;
      mem_wdata  <= mem_wdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (STARVE_MAX=4, TIMEOUT=8).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst, clk_en;
  logic        inst_rd_en;
  logic [31:0] inst_addr;
  logic        inst_ready, inst_err;
  logic [31:0] inst_rdata;
  logic        data_rd_en, data_wr_en;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [1:0]  data_size;
  logic        data_ready, data_err;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.STARVE_MAX(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .inst_rd_en(inst_rd_en), .inst_addr(inst_addr), .inst_ready(inst_ready),
    .inst_rdata(inst_rdata), .inst_err(inst_err),
    .data_rd_en(data_rd_en), .data_wr_en(data_wr_en), .data_addr(data_addr),
    .data_size(data_size), .data_wdata(data_wdata), .data_ready(data_ready),
    .data_rdata(data_rdata), .data_err(data_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one bus transaction: wait for mem_req, grant, respond, return to IDLE.
  task automatic serve(input logic [31:0] rdat, output logic [31:0] a, output logic [3:0] b,
                       output logic [31:0] w, output logic we, output logic ir,
                       output logic dr, output logic er);
    int n = 0;
    while (!mem_req && n < 20) begin
      step();
      n++;
    end
    chk("req_seen", {31'b0, mem_req}, 32'd1);
    a = mem_addr; b = mem_be; w = mem_wdata; we = mem_we;
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = rdat;
    step();
    mem_rvalid = 1'b0;
    ir = inst_ready; dr = data_ready; er = inst_err | data_err;
    step();
  endtask

  logic [31:0] a, w;
  logic [3:0]  b;
  logic        we, ir, dr, er;
  logic [31:0] exp_order [6];

  initial begin
    rst = 1'b1; clk_en = 1'b1;
    inst_rd_en = 1'b0; inst_addr = '0;
    data_rd_en = 1'b0; data_wr_en = 1'b0; data_addr = '0; data_size = 2'b10; data_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    exp_order = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h200, 32'h300};
    step(); step();
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst_ready", {30'b0, inst_ready, data_ready}, 32'd0);
    chk("rst_inst_rdata", inst_rdata, 32'd0);
    rst = 1'b0;
    step();

    // Minimum-latency fetch
    inst_rd_en = 1'b1; inst_addr = 32'h100;
    step();
    chk("f_req", {31'b0, mem_req}, 32'd1);
    chk("f_addr", mem_addr, 32'h100);
    chk("f_be_we", {27'b0, mem_be, mem_we}, {27'b0, 4'b1111, 1'b0});
    chk("f_ready_early", {31'b0, inst_ready}, 32'd0);
    mem_gnt = 1'b1;
    step();
    chk("f_req_drop", {31'b0, mem_req}, 32'd0);
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_rvalid = 1'b0; inst_rd_en = 1'b0;
    chk("f_ready", {30'b0, inst_ready, inst_err}, 32'b10);
    chk("f_rdata", inst_rdata, 32'hDEADBEEF);
    step();
    chk("f_ready_pulse", {31'b0, inst_ready}, 32'd0);

    // Store byte to 0x1003
    data_wr_en = 1'b1; data_addr = 32'h1003; data_size = 2'b00; data_wdata = 32'h0000_00AB;
    serve(32'h0, a, b, w, we, ir, dr, er);
    data_wr_en = 1'b0;
    chk("sb_addr", a, 32'h1000);
    chk("sb_be_we", {27'b0, b, we}, {27'b0, 4'b1000, 1'b1});
    chk("sb_wdata", w, 32'hABABABAB);
    chk("sb_ready", {29'b0, ir, dr, er}, 32'b010);

    // Store half to 0x2002
    data_wr_en = 1'b1; data_addr = 32'h2002; data_size = 2'b01; data_wdata = 32'hFFFF_1234;
    serve(32'h0, a, b, w, we, ir, dr, er);
    data_wr_en = 1'b0;
    chk("sh_be", {28'b0, b}, {28'b0, 4'b1100});
    chk("sh_wdata", w, 32'h12341234);

    // Word load from 0x3004
    data_rd_en = 1'b1; data_addr = 32'h3004; data_size = 2'b10;
    serve(32'hCAFEF00D, a, b, w, we, ir, dr, er);
    data_rd_en = 1'b0;
    chk("lw_be_we", {27'b0, b, we}, {27'b0, 4'b1111, 1'b0});
    chk("lw_rdata", data_rdata, 32'hCAFEF00D);
    chk("lw_ready", {29'b0, ir, dr, er}, 32'b010);

    // Misaligned half store: error at N+1, no bus cycle
    data_wr_en = 1'b1; data_addr = 32'h2001; data_size = 2'b01;
    step();
    data_wr_en = 1'b0;
    chk("mis_ready_err", {30'b0, data_ready, data_err}, 32'b11);
    chk("mis_no_req", {31'b0, mem_req}, 32'd0);
    step();
    chk("mis_pulse", {30'b0, data_ready, mem_req}, 32'd0);
    step();

    // Starvation: fetch held while loads arrive back to back
    inst_rd_en = 1'b1; inst_addr = 32'h200;
    data_rd_en = 1'b1; data_addr = 32'h300; data_size = 2'b10;
    for (int i = 0; i < 6; i++) begin
      serve(32'h1000 + i, a, b, w, we, ir, dr, er);
      chk($sformatf("grant_%0d", i), a, exp_order[i]);
      if (a == 32'h200) inst_rd_en = 1'b0;
    end
    data_rd_en = 1'b0;
    chk("starve_last_rdata", data_rdata, 32'h1005);
    step();

    // Bus timeout: mem_gnt never arrives
    inst_rd_en = 1'b1; inst_addr = 32'h400;
    for (int i = 0; i < 8; i++) step();
    chk("tmo_req_held", {31'b0, mem_req}, 32'd1);
    step();
    inst_rd_en = 1'b0;
    chk("tmo_req_drop", {31'b0, mem_req}, 32'd0);
    chk("tmo_ready_err", {30'b0, inst_ready, inst_err}, 32'b11);
    chk("tmo_rdata", inst_rdata, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h55;
    step(); step();
    mem_rvalid = 1'b0;
    chk("tmo_stray", {29'b0, inst_ready, data_ready, mem_req}, 32'd0);
    chk("tmo_stray_rdata", inst_rdata, 32'd0);

    // Clock enable low freezes arbitration
    clk_en = 1'b0; inst_rd_en = 1'b1; inst_addr = 32'h480;
    step(); step();
    chk("clken_hold", {31'b0, mem_req}, 32'd0);
    clk_en = 1'b1;
    serve(32'h0BAD_CAFE, a, b, w, we, ir, dr, er);
    inst_rd_en = 1'b0;
    chk("clken_resume", inst_rdata, 32'h0BADCAFE);

    // Reset while waiting for the response
    inst_rd_en = 1'b1; inst_addr = 32'h500;
    step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; rst = 1'b1; inst_rd_en = 1'b0;
    step();
    rst = 1'b0;
    chk("rr_idle", {29'b0, mem_req, inst_ready, data_ready}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h77;
    step();
    mem_rvalid = 1'b0;
    chk("rr_no_ready", {30'b0, inst_ready, mem_req}, 32'd0);
    chk("rr_rdata", inst_rdata, 32'd0);
    inst_rd_en = 1'b1; inst_addr = 32'h600;
    serve(32'h12345678, a, b, w, we, ir, dr, er);
    inst_rd_en = 1'b0;
    chk("rr_next_addr", a, 32'h600);
    chk("rr_next_ready", {29'b0, ir, dr, er}, 32'b100);
    chk("rr_next_rdata", inst_rdata, 32'h12345678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
